// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end:
// sequencer states, target indices and command field positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DISCARD
    } state_e;

    localparam int TGT_MEM_WR = 0;
    localparam int TGT_MEM_RD = 1;
    localparam int TGT_REG    = 2;
    localparam int TGT_CAP    = 3;

    localparam int CMD_TGT_MSB = 3;
    localparam int CMD_TGT_LSB = 0;
    localparam int CMD_TGT_W   = CMD_TGT_MSB - CMD_TGT_LSB + 1;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bundle between the SCK/CS synchroniser, the command
// sequencer and the spi_* target blocks.
interface spi_cmd_sequencer_if #(
    parameter int NT = 4
);
    logic          cs_n;
    logic          rising;
    logic          falling;
    logic          si;
    logic          so;
    logic [7:0]    status_in;
    logic [NT-1:0] so_tgt;
    logic [NT-1:0] sel_tgt;
    logic          reset_flag;
    logic [7:0]    cmd;
    logic          cmd_valid;
    logic          cmd_err;

    modport master (
        output cs_n, rising, falling, si, status_in, so_tgt,
        input  so, sel_tgt, reset_flag, cmd, cmd_valid, cmd_err
    );

    modport slave (
        input  cs_n, rising, falling, si, status_in, so_tgt,
        output so, sel_tgt, reset_flag, cmd, cmd_valid, cmd_err
    );
endinterface

// File: rtl/spi_cmd_sequencer_shift.sv
// Serial shifter: samples si on rising, presents a loaded
// byte MSB first on falling, flags the Nth sampled bit.
module shift_register #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reset_flag,
    input  logic [N-1:0] load_val,
    input  logic         rise_en,
    input  logic         si,
    input  logic         fall_en,
    output logic         so,
    output logic [N-1:0] data,
    output logic         done_strobe
);
    localparam int CW = $clog2(N);

    logic [N-1:0]  in_q, in_d;
    logic [N-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        in_d  = in_q;
        out_d = out_q;
        cnt_d = cnt_q;
        if (reset_flag) begin
            in_d  = '0;
            out_d = load_val;
            cnt_d = '0;
        end else if (rise_en) begin
            in_d  = {in_q[N-2:0], si};
            cnt_d = cnt_q + 1'b1;
        end else if (fall_en) begin
            out_d = {out_q[N-2:0], 1'b0};
        end
    end

    // data includes the bit being sampled so the full byte is
    // available in the same cycle as done_strobe
    assign data        = {in_q[N-2:0], si};
    assign done_strobe = rise_en && (cnt_q == CW'(N - 1));
    assign so          = out_q[N-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes the first byte of each CS frame as a command and
// routes the rest of the frame to one selected target.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int         NT     = 4,
    parameter logic [7:0] STATUS = 8'hA5
) (
    input logic                clk,
    input logic                rst,
    spi_cmd_sequencer_if.slave bus
);
    state_e        state_q, state_d;
    logic [NT-1:0] sel_q, sel_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          rflag_q, rflag_d;
    logic          cv_q, cv_d;
    logic          ce_q, ce_d;
    logic          armed_q, armed_d;

    logic                 start;
    logic                 rise_en;
    logic                 fall_en;
    logic                 sr_so;
    logic                 done;
    logic [7:0]           sr_data;
    logic [7:0]           load_val;
    logic [CMD_TGT_W-1:0] idx;
    logic [NT-1:0]        hot;
    logic                 so_mux;

    // armed_q remembers cs_n high last clk, so a frame already
    // running when reset releases is not picked up mid-way
    assign start    = (state_q == IDLE) && !bus.cs_n && armed_q;
    assign rise_en  = (state_q == CMD) && !bus.cs_n && bus.rising;
    assign fall_en  = (state_q == CMD) && !bus.cs_n && bus.falling
                      && !bus.rising;
    assign load_val = (bus.status_in == 8'h00) ? STATUS : bus.status_in;
    assign idx      = sr_data[CMD_TGT_MSB:CMD_TGT_LSB];

    shift_register #(.N(8)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .reset_flag (start),
        .load_val   (load_val),
        .rise_en    (rise_en),
        .si         (bus.si),
        .fall_en    (fall_en),
        .so         (sr_so),
        .data       (sr_data),
        .done_strobe(done)
    );

    always_comb begin
        hot = '0;
        for (int i = 0; i < NT; i++) begin
            hot[i] = (int'(idx) == i);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cmd_d   = cmd_q;
        rflag_d = 1'b0;
        cv_d    = 1'b0;
        ce_d    = 1'b0;
        armed_d = bus.cs_n;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rflag_d = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.cs_n) begin
                    state_d = IDLE;
                end else if (done) begin
                    cmd_d = sr_data;
                    if (int'(idx) < NT) begin
                        cv_d    = 1'b1;
                        sel_d   = hot;
                        state_d = DATA;
                    end else begin
                        ce_d    = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            DATA, DISCARD: begin
                if (bus.cs_n) begin
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        so_mux = 1'b0;
        unique case (state_q)
            CMD:     so_mux = sr_so;
            DATA:    so_mux = |(bus.so_tgt & sel_q);
            default: so_mux = 1'b0;
        endcase
    end

    assign bus.so         = so_mux;
    assign bus.sel_tgt    = sel_q;
    assign bus.reset_flag = rflag_q;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = cv_q;
    assign bus.cmd_err    = ce_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cmd_q   <= 8'h00;
            rflag_q <= 1'b0;
            cv_q    <= 1'b0;
            ce_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            rflag_q <= rflag_d;
            cv_q    <= cv_d;
            ce_q    <= ce_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: command decode, status
// shift-out, invalid/aborted frames and reset behaviour.
module tb_spi_cmd_sequencer;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_cmd_sequencer_if #(.NT(4)) bus ();

    spi_cmd_sequencer #(
        .NT    (4),
        .STATUS(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic       cv_seen;
    logic       ce_seen;
    logic [7:0] rx;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Top n bits of tx, MSB first; so is captured as the master
    // would see it at each SCK rising edge.
    task automatic send_bits(input logic [7:0] tx, input int n);
        cv_seen = 1'b0;
        ce_seen = 1'b0;
        rx      = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.si     = tx[i];
            bus.rising = 1'b1;
            rx[i]      = bus.so;
            tick();
            bus.rising = 1'b0;
            cv_seen    = cv_seen | bus.cmd_valid;
            ce_seen    = ce_seen | bus.cmd_err;
            bus.falling = 1'b1;
            tick();
            bus.falling = 1'b0;
            tick();
        end
    endtask

    task automatic start_frame(input string tag);
        bus.cs_n = 1'b0;
        tick();
        check({tag, "_rflag_hi"}, bus.reset_flag, 1);
        tick();
        check({tag, "_rflag_lo"}, bus.reset_flag, 0);
    endtask

    task automatic end_frame(input string tag);
        bus.cs_n = 1'b1;
        tick();
        check({tag, "_sel_clear"}, bus.sel_tgt, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.cs_n      = 1'b1;
        bus.rising    = 1'b0;
        bus.falling   = 1'b0;
        bus.si        = 1'b0;
        bus.status_in = 8'h00;
        bus.so_tgt    = '0;
        repeat (2) tick();
        check("rst_so", bus.so, 0);
        check("rst_sel", bus.sel_tgt, 0);
        check("rst_rflag", bus.reset_flag, 0);
        check("rst_cmd", bus.cmd, 8'h00);
        check("rst_cv", bus.cmd_valid, 0);
        check("rst_ce", bus.cmd_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: cmd 00 -> target 0, default status A5
        start_frame("t1");
        send_bits(8'h00, 8);
        check("t1_status", rx, 8'hA5);
        check("t1_cv", cv_seen, 1);
        check("t1_ce", ce_seen, 0);
        check("t1_sel", bus.sel_tgt, 4'b0001);
        check("t1_cv_pulse", bus.cmd_valid, 0);
        bus.so_tgt = 4'b0001;
        #1;
        check("t1_so_hi", bus.so, 1);
        send_bits(8'h5A, 8);
        check("t1_sel_b1", bus.sel_tgt, 4'b0001);
        bus.so_tgt = 4'b1110;
        #1;
        check("t1_so_lo", bus.so, 0);
        send_bits(8'hC3, 8);
        send_bits(8'h99, 8);
        check("t1_sel_b3", bus.sel_tgt, 4'b0001);
        end_frame("t1");
        check("t1_so_idle", bus.so, 0);

        // 2: live status 3C, cmd 02
        bus.status_in = 8'h3C;
        start_frame("t2");
        send_bits(8'h02, 8);
        check("t2_status", rx, 8'h3C);
        check("t2_cv", cv_seen, 1);
        check("t2_cmd", bus.cmd, 8'h02);
        check("t2_sel", bus.sel_tgt, 4'b0100);
        end_frame("t2");

        // 3: out-of-range target index
        bus.status_in = 8'h00;
        start_frame("t3");
        send_bits(8'h07, 8);
        check("t3_ce", ce_seen, 1);
        check("t3_cv", cv_seen, 0);
        check("t3_cmd", bus.cmd, 8'h07);
        check("t3_sel", bus.sel_tgt, 0);
        bus.so_tgt = 4'b1111;
        send_bits(8'hFF, 8);
        check("t3_so_discard", rx, 8'h00);
        check("t3_sel_after", bus.sel_tgt, 0);
        end_frame("t3");

        // 4: abort after 5 bits, then a clean cmd 01
        start_frame("t4a");
        send_bits(8'h01, 5);
        check("t4_cv", cv_seen, 0);
        check("t4_ce", ce_seen, 0);
        bus.cs_n = 1'b1;
        tick();
        check("t4_cmd_kept", bus.cmd, 8'h07);
        check("t4_sel_abort", bus.sel_tgt, 0);
        tick();
        start_frame("t4b");
        send_bits(8'h01, 8);
        check("t4_cv2", cv_seen, 1);
        check("t4_cmd", bus.cmd, 8'h01);
        check("t4_sel", bus.sel_tgt, 4'b0010);
        bus.so_tgt = 4'b0010;
        #1;
        check("t4_so_tgt1", bus.so, 1);

        // 5: asynchronous reset in DATA, released with cs_n low
        #2;
        rst = 1'b1;
        #1;
        check("t5_sel", bus.sel_tgt, 0);
        check("t5_so", bus.so, 0);
        check("t5_cmd", bus.cmd, 8'h00);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_rflag", bus.reset_flag, 0);
        end
        send_bits(8'h02, 8);
        check("t5_no_cv", cv_seen, 0);
        check("t5_sel_idle", bus.sel_tgt, 0);
        bus.cs_n = 1'b1;
        repeat (2) tick();
        start_frame("t5");

        // 6: cs_n rises together with the 8th rising edge
        send_bits(8'h02, 7);
        bus.si     = 1'b0;
        bus.rising = 1'b1;
        bus.cs_n   = 1'b1;
        tick();
        bus.rising = 1'b0;
        check("t6_cv", bus.cmd_valid, 0);
        check("t6_ce", bus.cmd_err, 0);
        check("t6_cmd", bus.cmd, 8'h00);
        check("t6_sel", bus.sel_tgt, 0);
        tick();
        start_frame("t6");
        send_bits(8'h03, 8);
        check("t6_cv2", cv_seen, 1);
        check("t6_sel2", bus.sel_tgt, 4'b1000);
        end_frame("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
